stack_ctrl: RTL and testbench
=============================

// Module: stack_ctrl
// PURPOSE
//  Sequencer for the 8-bit x 4-deep bit-sliced stack. Accepts push/pop/peek/replace
//  requests over a valid/ready handshake and drives the stack's s/i inputs. Tracks
//  occupancy, because the stack has no reset and no depth state, and returns popped
//  or peeked data. Flags overflow/underflow instead of corrupting the stack.
// PARAMETERS
//  W      8  data width; equals stack slice count
//  DEPTH  4  stack entries; equals stack register length
// PORTS
//  ck         in   1        clock; all state updates on posedge
//  rst_n      in   1        asynchronous reset, active low
//  req_valid  in   1        request present
//  req_op     in   2        00 peek, 01 push, 10 pop, 11 replace (pop then push)
//  req_data   in   W        push/replace data
//  req_ready  out  1        controller can accept a request this cycle
//  rsp_valid  out  1        1-cycle pulse: rsp_data valid (pop/peek/replace)
//  rsp_data   out  W        top-of-stack value before the op
//  err        out  1        1-cycle pulse: request rejected (overflow/underflow)
//  stk_s      out  2        to stack s: 10 push, 01 pop, 00 hold
//  stk_i      out  W        to stack i
//  stk_T      in   W        from stack T (current top)
//  depth      out  3        entries held, 0..DEPTH
//  empty/full out  1 each   depth==0 / depth==DEPTH
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, depth=0, stk_s=00, stk_i=0, rsp_valid=0,
//    rsp_data=0, err=0, req_ready=0 while rst_n low. Stack contents are invalid after
//    reset and are never read while depth==0. Reset mid-op aborts the op; no s pulse completes.
//  - All outputs are registered. Handshake: transfer on posedge when req_valid & req_ready.
//    req_ready=1 only in IDLE. req_data/req_op are sampled at the transfer edge only.
//  - FSM states: IDLE, PUSH, POP, RPOP (replace pop phase), RPUSH (replace push phase).
//  - IDLE, accepted at edge k:
//    peek (depth>0): rsp_data<=stk_T; rsp_valid pulses in cycle k+1; stays IDLE.
//    push (!full): stk_i<=req_data, stk_s<=10 -> PUSH.
//    pop (!empty): rsp_data<=stk_T, stk_s<=01 -> POP.
//    replace (!empty): rsp_data<=stk_T, stk_s<=01, latch data -> RPOP.
//  - PUSH/POP (1 cycle): the stack shifts at the following edge. Same edge: stk_s<=00,
//    depth+/-1, rsp_valid pulses for pop, -> IDLE.
//  - RPOP: stk_s<=10, stk_i<=latched data -> RPUSH. RPUSH: stk_s<=00, rsp_valid pulse,
//    depth unchanged, -> IDLE.
//  - Latency acceptance->stack updated: push/pop 2 edges, replace 3 edges, peek 0 stack edges.
//    Peak throughput: 1 peek/cycle; 1 push or pop per 2 cycles.
//  - rsp_data is sampled only in IDLE, so stk_T is always settled (no op in flight).
//  - Rejections: push when full; pop/peek/replace when empty. The request is still accepted
//    (handshake completes), err pulses in cycle k+1, stk_s stays 00, depth unchanged, no rsp_valid.
//  - Concurrent outputs: rsp_valid and err are never both 1. stk_s is never 11.
//  - depth saturates by construction; it never wraps past DEPTH or below 0.
// TESTING
//  1 reset then push 0xA5,0x3C,0xFF,0x01 -> depth 1..4, full=1, stk_T=0x01, stk_s=10 one cycle each
//  2 from full: push 0x77 -> err pulse, depth stays 4, stk_s stays 00; pop x4 -> rsp_data
//    0x01,0xFF,0x3C,0xA5, then empty=1
//  3 empty: pop, peek, replace each -> err pulse, no rsp_valid, depth 0
//  4 push 0x12, replace 0x34 -> rsp_data 0x12, depth 1, stk_T 0x34; peek -> 0x34, stk_s stays 00
//  5 req_valid held high with random ops for 500 cycles -> req_ready low during PUSH/POP/RPOP/RPUSH;
//    scoreboard model matches rsp_data/err/depth
//  6 rst_n low during POP cycle (depth 3) -> stk_s=00 immediately, depth 0, next pop -> err

Source files
------------

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response handshake between a client and stack_ctrl.
interface stack_ctrl_if #(parameter int W = 8);
  logic         req_valid;
  logic [1:0]   req_op;
  logic [W-1:0] req_data;
  logic         req_ready;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         err;
  modport master (output req_valid, req_op, req_data, input req_ready, rsp_valid, rsp_data, err);
  modport slave  (input req_valid, req_op, req_data, output req_ready, rsp_valid, rsp_data, err);
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences push/pop/peek/replace onto a reset-less shift-register stack and tracks its depth.
module stack_ctrl #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         ck,
  input  logic         rst_n,
  stack_ctrl_if.slave  bus,
  output logic [1:0]   stk_s_o,
  output logic [W-1:0] stk_i_o,
  input  logic [W-1:0] stk_T_i,
  output logic [2:0]   depth_o,
  output logic         empty_o,
  output logic         full_o
);
  typedef enum logic [2:0] {IDLE, PUSH, POP, RPOP, RPUSH} state_t;
  localparam logic [1:0] OP_PEEK = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10;
  localparam logic [1:0] S_HOLD = 2'b00, S_PUSH = 2'b10, S_POP = 2'b01;
  state_t       state_q;
  logic [2:0]   depth_q;
  logic [1:0]   stk_s_q;
  logic [W-1:0] stk_i_q, rsp_data_q, data_q;
  logic         rsp_valid_q, err_q, ready_q;
  logic         empty, full, reject;
  assign empty  = depth_q == 3'd0;
  assign full   = depth_q == 3'(DEPTH);
  assign reject = (bus.req_op == OP_PUSH) ? full : empty;
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      depth_q     <= 3'd0;
      stk_s_q     <= S_HOLD;
      stk_i_q     <= '0;
      rsp_data_q  <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (bus.req_valid && ready_q) begin
            if (reject) err_q <= 1'b1;
            else begin
              // stk_T is settled here: nothing is in flight while IDLE
              if (bus.req_op != OP_PUSH) rsp_data_q <= stk_T_i;
              case (bus.req_op)
                OP_PEEK: rsp_valid_q <= 1'b1;
                OP_PUSH: begin
                  stk_i_q <= bus.req_data;
                  stk_s_q <= S_PUSH;
                  state_q <= PUSH;
                  ready_q <= 1'b0;
                end
                OP_POP: begin
                  stk_s_q <= S_POP;
                  state_q <= POP;
                  ready_q <= 1'b0;
                end
                default: begin
                  data_q  <= bus.req_data;
                  stk_s_q <= S_POP;
                  state_q <= RPOP;
                  ready_q <= 1'b0;
                end
              endcase
            end
          end
        end
        PUSH: begin
          stk_s_q <= S_HOLD;
          depth_q <= depth_q + 3'd1;
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        POP: begin
          stk_s_q     <= S_HOLD;
          depth_q     <= depth_q - 3'd1;
          rsp_valid_q <= 1'b1;
          state_q     <= IDLE;
          ready_q     <= 1'b1;
        end
        RPOP: begin
          stk_s_q <= S_PUSH;
          stk_i_q <= data_q;
          state_q <= RPUSH;
        end
        RPUSH: begin
          stk_s_q     <= S_HOLD;
          rsp_valid_q <= 1'b1;
          state_q     <= IDLE;
          ready_q     <= 1'b1;
        end
        default: begin
          stk_s_q <= S_HOLD;
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.err       = err_q;
  assign stk_s_o       = stk_s_q;
  assign stk_i_o       = stk_i_q;
  assign depth_o       = depth_q;
  assign empty_o       = empty;
  assign full_o        = full;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: drives stack_ctrl against a behavioural shift-register stack and checks it with a request-level model.
module tb_stack_ctrl;
  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] stk_s;
  logic [7:0] stk_i, stk_T;
  logic [2:0] depth;
  logic       empty, full;
  int checks = 0, failures = 0;
  int err_cnt = 0, rsp_cnt = 0;
  logic [7:0] last_rsp = 8'h00;
  stack_ctrl_if #(.W(8)) bus ();
  stack_ctrl #(.W(8), .DEPTH(4)) dut (
    .ck(ck), .rst_n(rst_n), .bus(bus), .stk_s_o(stk_s), .stk_i_o(stk_i),
    .stk_T_i(stk_T), .depth_o(depth), .empty_o(empty), .full_o(full)
  );
  always #5 ck = ~ck;
  // physical stack: no reset, shifts on s=10 (push) / s=01 (pop)
  logic [7:0] phys [4];
  always @(posedge ck) begin
    if (stk_s == 2'b10) begin
      phys[3] <= phys[2]; phys[2] <= phys[1]; phys[1] <= phys[0]; phys[0] <= stk_i;
    end else if (stk_s == 2'b01) begin
      phys[0] <= phys[1]; phys[1] <= phys[2]; phys[2] <= phys[3];
    end
  end
  assign stk_T = phys[0];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // request-level model: logical stack plus a schedule of future output effects
  logic [7:0] mq [$];
  int  sch_s [1:4], sch_i [1:4], sch_rv [1:4], sch_er [1:4], sch_dd [1:4], sch_bz [1:4];
  int  e_s = 0, e_i = 0, e_rv = 0, e_er = 0, e_depth = 0, e_rd = 0, e_ready = 0;
  always @(negedge ck) begin
    if (!rst_n) begin
      mq.delete();
      for (int j = 1; j <= 4; j++) begin
        sch_s[j] = 0; sch_i[j] = 0; sch_rv[j] = 0; sch_er[j] = 0; sch_dd[j] = 0; sch_bz[j] = 0;
      end
      e_s = 0; e_i = 0; e_rv = 0; e_er = 0; e_depth = 0; e_rd = 0; e_ready = 0;
    end
    chk("req_ready", bus.req_ready, e_ready);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("err", bus.err, e_er);
    chk("rsp_data", bus.rsp_data, e_rd);
    chk("stk_s", stk_s, e_s);
    if (e_s == 2) chk("stk_i", stk_i, e_i);
    chk("depth", depth, e_depth);
    chk("empty", empty, e_depth == 0);
    chk("full", full, e_depth == 4);
    if (rst_n) begin
      if (bus.rsp_valid) begin last_rsp = bus.rsp_data; rsp_cnt++; end
      if (bus.err) err_cnt++;
      if (bus.req_valid && e_ready) begin
        int op;
        int d;
        op = int'(bus.req_op);
        d  = int'(bus.req_data);
        if (op == 1 ? mq.size() == 4 : mq.size() == 0) sch_er[1] = 1;
        else begin
          if (op != 1) e_rd = mq[0];
          case (op)
            0: sch_rv[1] = 1;
            1: begin sch_s[1] = 2; sch_i[1] = d; sch_dd[2] = 1; sch_bz[1] = 1; mq.push_front(d[7:0]); end
            2: begin sch_s[1] = 1; sch_rv[2] = 1; sch_dd[2] = -1; sch_bz[1] = 1; void'(mq.pop_front()); end
            default: begin
              sch_s[1] = 1; sch_s[2] = 2; sch_i[2] = d; sch_rv[3] = 1;
              sch_bz[1] = 1; sch_bz[2] = 1; mq[0] = d[7:0];
            end
          endcase
        end
      end
      e_s = sch_s[1]; e_i = sch_i[1]; e_rv = sch_rv[1]; e_er = sch_er[1];
      e_depth += sch_dd[1]; e_ready = !sch_bz[1];
      for (int j = 1; j <= 3; j++) begin
        sch_s[j] = sch_s[j+1]; sch_i[j] = sch_i[j+1]; sch_rv[j] = sch_rv[j+1];
        sch_er[j] = sch_er[j+1]; sch_dd[j] = sch_dd[j+1]; sch_bz[j] = sch_bz[j+1];
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) begin @(posedge ck); #1; end
  endtask
  task automatic wait_ready();
    int n = 0;
    do begin @(negedge ck); n++; end while (!bus.req_ready && n < 20);
    if (!bus.req_ready) begin
      checks++; failures++;
      $display("FAIL xfer_timeout: req_ready 0 for %0d cycles, expected 1", n);
    end
  endtask
  task automatic xfer(input logic [1:0] op, input logic [7:0] d);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = d;
    wait_ready();
    @(posedge ck); #1;
    bus.req_valid = 1'b0;
  endtask
  initial begin
    int e0, r0;
    logic [7:0] pushv [4];
    logic [7:0] popv [4];
    pushv = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    popv  = '{8'h01, 8'hFF, 8'h3C, 8'hA5};
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = 8'h00;
    idle(2);
    chk("lit_reset_ready", bus.req_ready, 0);
    chk("lit_reset_depth", depth, 0);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      xfer(2'b01, pushv[i]);
      idle(1);
      chk("lit_push_depth", depth, i + 1);
    end
    chk("lit_full", full, 1);
    chk("lit_top", stk_T, 8'h01);
    e0 = err_cnt; r0 = rsp_cnt;
    xfer(2'b01, 8'h77);
    idle(2);
    chk("lit_overflow_err", err_cnt, e0 + 1);
    chk("lit_overflow_depth", depth, 4);
    for (int i = 0; i < 4; i++) begin
      xfer(2'b10, 8'h00);
      idle(3);
      chk("lit_pop_data", last_rsp, popv[i]);
    end
    chk("lit_pop_rsps", rsp_cnt, r0 + 4);
    chk("lit_empty", empty, 1);
    e0 = err_cnt; r0 = rsp_cnt;
    xfer(2'b10, 8'h00);
    xfer(2'b00, 8'h00);
    xfer(2'b11, 8'h55);
    idle(2);
    chk("lit_underflow_err", err_cnt, e0 + 3);
    chk("lit_underflow_norsp", rsp_cnt, r0);
    chk("lit_underflow_depth", depth, 0);
    xfer(2'b01, 8'h12);
    idle(2);
    xfer(2'b11, 8'h34);
    idle(4);
    chk("lit_replace_data", last_rsp, 8'h12);
    chk("lit_replace_depth", depth, 1);
    chk("lit_replace_top", stk_T, 8'h34);
    xfer(2'b00, 8'h00);
    idle(2);
    chk("lit_peek_data", last_rsp, 8'h34);
    bus.req_valid = 1'b1;
    repeat (500) begin
      bus.req_op   = 2'($urandom_range(0, 3));
      bus.req_data = 8'($urandom);
      idle(1);
    end
    bus.req_valid = 1'b0;
    idle(4);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) begin xfer(2'b01, 8'(8'h40 + i)); idle(1); end
    chk("lit_pre_abort_depth", depth, 3);
    bus.req_valid = 1'b1; bus.req_op = 2'b10;
    wait_ready();
    @(posedge ck); #1;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("lit_abort_s", stk_s, 0);
    chk("lit_abort_depth", depth, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    e0 = err_cnt;
    xfer(2'b10, 8'h00);
    idle(2);
    chk("lit_abort_pop_err", err_cnt, e0 + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
